// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage of the 4-stage 8-bit pipeline.
// Owns the PC, reads instruction memory combinationally and fills the IF/ID register.
// jmp words are predecoded here so the target is fetched on the very next cycle;
// the undefined opcode 2'b10 is squashed into a NOP bubble and flagged.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   imem_addr       instruction address (always equals pc)
//   imem_data       instruction word read at imem_addr, same cycle
//   stall           downstream hazard; holds PC and IF/ID
//   redir_valid     EX-stage redirect request (beats stall)
//   redir_pc        redirect target
//   ifid_instr      registered instruction to the decoder
//   ifid_pc         PC of ifid_instr (don't-care when ifid_valid = 0)
//   ifid_valid      ifid_instr is a real instruction
//   illegal_op      sticky: an opcode-2'b10 word was consumed
//   pc              current fetch PC
module instr_fetch_unit #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_data,
  input  logic              stall,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic [7:0]        ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic              ifid_valid,
  output logic              illegal_op,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);
  localparam logic [7:0]        Nop     = 8'h00;

  localparam logic [1:0] OpJmp     = 2'b11;
  localparam logic [1:0] OpIllegal = 2'b10;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        instr_q, instr_d;
  logic [ADDR_W-1:0] ifid_pc_q, ifid_pc_d;
  logic              valid_q, valid_d;
  logic              illegal_q, illegal_d;

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] jmp_target;

  assign pc_inc     = pc_q + ADDR_W'(1);  // wraps naturally at all-ones
  assign jmp_target = ADDR_W'(imem_data[5:0]);

  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    ifid_pc_d = ifid_pc_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;

    if (redir_valid) begin
      // Flush: the word at pc is discarded, so it cannot raise illegal_op.
      pc_d      = redir_pc;
      instr_d   = Nop;
      ifid_pc_d = pc_q;
      valid_d   = 1'b0;
    end else if (!stall) begin
      ifid_pc_d = pc_q;
      unique case (imem_data[7:6])
        OpJmp: begin
          // The jmp itself still flows to the decoder.
          pc_d    = jmp_target;
          instr_d = imem_data;
          valid_d = 1'b1;
        end
        OpIllegal: begin
          pc_d      = pc_inc;
          instr_d   = Nop;
          valid_d   = 1'b0;
          illegal_d = 1'b1;
        end
        default: begin
          pc_d    = pc_inc;
          instr_d = imem_data;
          valid_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= ResetPc;
      instr_q   <= Nop;
      ifid_pc_q <= ResetPc;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      ifid_pc_q <= ifid_pc_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

  assign pc         = pc_q;
  assign imem_addr  = pc_q;
  assign ifid_instr = instr_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_valid = valid_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a reference model computes each cycle's expected
// IF/ID and PC state and queues it; a negedge monitor pops and compares.
module tb_instr_fetch_unit;

  logic       clk;
  logic       rst_n;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic       stall;
  logic       redir_valid;
  logic [7:0] redir_pc;
  logic [7:0] ifid_instr;
  logic [7:0] ifid_pc;
  logic       ifid_valid;
  logic       illegal_op;
  logic [7:0] pc;

  logic [7:0] rom [256];
  assign imem_data = rom[imem_addr];

  instr_fetch_unit #(
    .ADDR_W  (8),
    .RESET_PC(0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .stall      (stall),
    .redir_valid(redir_valid),
    .redir_pc   (redir_pc),
    .ifid_instr (ifid_instr),
    .ifid_pc    (ifid_pc),
    .ifid_valid (ifid_valid),
    .illegal_op (illegal_op),
    .pc         (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    logic [7:0] pc;
    logic [7:0] instr;
    logic [7:0] ipc;
    logic       valid;
    logic       ill;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   check_en = 1'b0;

  task automatic compare(input string name, input exp_t e);
    bit bad;
    n_vec++;
    bad = (pc !== e.pc) || (imem_addr !== e.pc) || (ifid_instr !== e.instr) ||
          (ifid_valid !== e.valid) || (illegal_op !== e.ill) ||
          (e.valid && (ifid_pc !== e.ipc));
    if (bad) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got pc=%h addr=%h instr=%h ipc=%h v=%b ill=%b; required pc=%h instr=%h ipc=%h v=%b ill=%b",
               name, cyc, pc, imem_addr, ifid_instr, ifid_pc, ifid_valid, illegal_op,
               e.pc, e.instr, e.ipc, e.valid, e.ill);
    end
  endtask

  // Monitor: compare whatever expectation is due in the current cycle.
  always @(negedge clk) begin
    if (check_en) begin
      while (sbq.size() > 0 && sbq[0].tag < cyc) begin
        n_vec++;
        n_bad++;
        $display("FAIL stale_entry tag=%0d cyc=%0d", sbq[0].tag, cyc);
        void'(sbq.pop_front());
      end
      if (sbq.size() > 0 && sbq[0].tag == cyc) compare("ifid", sbq.pop_front());
    end
  end

  // Reference model state (plain integers, straight from the fetch rules).
  int m_pc, m_instr, m_ipc;
  bit m_valid, m_ill;

  task automatic model_reset();
    m_pc = 0; m_instr = 0; m_ipc = 0; m_valid = 0; m_ill = 0;
  endtask

  task automatic model_step(input bit st, input bit rd, input int rpc);
    int w;
    w = int'(rom[m_pc]);
    if (rd) begin
      m_ipc = m_pc; m_instr = 0; m_valid = 0; m_pc = rpc;
    end else if (!st) begin
      m_ipc = m_pc;
      if (w / 64 == 3) begin
        m_instr = w; m_valid = 1; m_pc = w % 64;
      end else if (w / 64 == 2) begin
        m_instr = 0; m_valid = 0; m_ill = 1; m_pc = (m_pc + 1) % 256;
      end else begin
        m_instr = w; m_valid = 1; m_pc = (m_pc + 1) % 256;
      end
    end
  endtask

  task automatic push_expect();
    exp_t e;
    e.tag = cyc + 1;
    e.pc = 8'(m_pc); e.instr = 8'(m_instr); e.ipc = 8'(m_ipc);
    e.valid = m_valid; e.ill = m_ill;
    sbq.push_back(e);
  endtask

  task automatic check_reset(input string name);
    exp_t e;
    e.tag = cyc; e.pc = 8'h00; e.instr = 8'h00; e.ipc = 8'h00; e.valid = 0; e.ill = 0;
    compare(name, e);
    n_vec++;
    if (ifid_pc !== 8'h00) begin
      n_bad++;
      $display("FAIL %s_ifid_pc: got %h required 00", name, ifid_pc);
    end
  endtask

  // Drive one cycle's inputs, queue the expected result, advance past the clock edge.
  task automatic run_cycle(input bit st, input bit rd, input int rpc);
    stall = st; redir_valid = rd; redir_pc = 8'(rpc);
    model_step(st, rd, rpc);
    push_expect();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  int stalls_done;
  bit redir1_done, redir2_done;

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[0] = 8'h01; rom[1] = 8'h49; rom[2] = 8'h02; rom[3] = 8'hD4;
    rom[20] = 8'hC5;  // jmp 5
    rom[5] = 8'h8A; rom[6] = 8'h01; rom[7] = 8'h02; rom[8] = 8'h03; rom[9] = 8'h04;
    rom[10] = 8'h05;
    rom[40] = 8'h11; rom[41] = 8'h12; rom[42] = 8'h13; rom[43] = 8'h14;
    rom[254] = 8'h21; rom[255] = 8'h22;

    stall = 0; redir_valid = 0; redir_pc = 0;
    rst_n = 1'b0;
    #3;
    check_reset("reset_async");
    repeat (2) @(negedge clk);
    check_reset("reset_held");
    rst_n = 1'b1;
    model_reset();
    cyc = 0;
    check_en = 1'b1;

    // Directed walk: sequential run, jmp, illegal, stall at 7, redirect-with-stall, wrap.
    stalls_done = 0; redir1_done = 0; redir2_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_pc == 7 && stalls_done < 3) begin
        stalls_done++;
        run_cycle(1'b1, 1'b0, 0);
      end else if (m_pc == 10 && !redir1_done) begin
        redir1_done = 1;
        run_cycle(1'b1, 1'b1, 40);
      end else if (m_pc == 43 && !redir2_done) begin
        redir2_done = 1;
        run_cycle(1'b0, 1'b1, 254);
      end else begin
        run_cycle(1'b0, 1'b0, 0);
      end
    end

    // Random phase: fresh ROM contents every 100 cycles.
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 0) for (int a = 0; a < 256; a++) rom[a] = 8'($urandom_range(0, 255));
      run_cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                int'($urandom_range(0, 255)));
    end
    @(negedge clk);

    // Reset asserted mid-stall must clear everything without a clock edge.
    stall = 1'b1; redir_valid = 1'b0;
    @(posedge clk);
    #1;
    check_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset("reset_mid_stall");

    n_vec++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending entries required 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

- Fetch stage of the 4-stage pipelined 8-bit processor: owns the program counter, reads instruction memory, and fills the IF/ID register consumed by the opcode decoder.
- Acts as the producer side of the opcode interface. It predecodes each fetched word so `jmp` redirects the PC with zero bubbles, and accepts late redirects from EX.
- It squashes the undefined opcode 2'b10 into a NOP before it ever reaches the decoder.

## Interface

Parameters:
- `ADDR_W`, default 8: PC / instruction-memory address width (≥6).
- `RESET_PC`, default 0: PC value loaded at reset.

Ports:
- `clk`, input, 1: sole clock; all state on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `imem_addr`, output, ADDR_W: instruction address; equals `pc`, driven combinationally.
- `imem_data`, input, 8: instruction word; combinational read of `imem_addr`, valid the same cycle.
- `stall`, input, 1: downstream hazard; holds PC and IF/ID.
- `redir_valid`, input, 1: EX-stage redirect request.
- `redir_pc`, input, ADDR_W: redirect target.
- `ifid_instr`, output, 8: registered instruction to the decoder.
- `ifid_pc`, output, ADDR_W: registered PC of `ifid_instr`.
- `ifid_valid`, output, 1: `ifid_instr` is a real instruction (0 = bubble).
- `illegal_op`, output, 1: sticky flag; an opcode-2'b10 word was fetched.
- `pc`, output, ADDR_W: current fetch PC.

## Operation

Instruction format:
- Opcode is `[7:6]`: 00 = addi, 01 = sll, 11 = jmp, 10 = undefined.
- For jmp, `[5:0]` is the absolute target, zero-extended to ADDR_W.

NOP encoding is 8'h00.

Next-PC selection, evaluated each cycle, with priority from highest to lowest:
1. `redir_valid` = 1: next PC = `redir_pc`; IF/ID loads NOP with `ifid_valid` = 0 (flush). This happens even if `stall` = 1.
2. `stall` = 1: PC, `ifid_instr`, `ifid_pc` and `ifid_valid` all hold.
3. `imem_data[7:6]` = 2'b11: next PC = {0, `imem_data[5:0]`}; IF/ID loads the jmp word with valid = 1, so the decoder still sees the jmp.
4. `imem_data[7:6]` = 2'b10: next PC = `pc`+1; IF/ID loads NOP with valid = 0; `illegal_op` is set.
5. Otherwise: next PC = `pc`+1; IF/ID loads `imem_data`, `pc` and valid = 1.

Rules:
- `ifid_pc` always captures the `pc` of the cycle that was loaded. On a flush it captures the current `pc`; its value is don't-care when valid = 0.
- PC increment wraps modulo 2^ADDR_W: all-ones + 1 = 0.
- `illegal_op` is not set during a stall or redirect cycle, because the word is not consumed.
- `illegal_op` is cleared only by `rst_n`.
- No internal FSM beyond the PC/IF/ID registers. The state is {running, stalled} as given by `stall` in the current cycle.

## Timing

- Reset (async assert, no clock needed):
  - `pc` = `RESET_PC`
  - `ifid_instr` = 8'h00
  - `ifid_pc` = `RESET_PC`
  - `ifid_valid` = 0
  - `illegal_op` = 0
- First fetch happens on the first rising edge after `rst_n` deasserts. Deassertion is synchronised externally.
- Latency: a word at `imem_addr` in cycle N appears on `ifid_*` in cycle N+1.
- Throughput: 1 instruction per cycle when `stall` = 0.
- jmp costs 0 bubbles: the target is fetched in the cycle after the jmp is fetched.
- EX redirect costs 1 flushed IF/ID slot. `redir_pc` is fetched in the cycle after `redir_valid`.
- Reset asserted mid-operation reinitialises all outputs immediately, with no partial update.
- `stall` and `redir_valid` high together: the redirect wins, as in Operation.

## Test plan

- Reset then run with ROM 0:8'h01, 1:8'h49, 2:8'h02 and `stall` = 0. Required response:
  - cycle 1: `ifid_instr` = 01, `ifid_pc` = 0, valid = 1
  - cycle 2: 49 / 1
  - cycle 3: 02 / 2
- jmp: ROM 3:8'hC0|6'd20. Required: after 3 is fetched, `pc` = 20 next cycle; `ifid_instr` = 8'hD4 with valid = 1; no bubble.
- Illegal: ROM 5:8'h8A. Required: `ifid_valid` = 0, `ifid_instr` = 00, `illegal_op` = 1 and stays 1; `pc` proceeds 5→6.
- Stall 3 cycles at pc = 7. Required: `pc` and `ifid_*` frozen for 3 cycles, then resume at 8 with no lost or duplicate instruction.
- Redirect with `stall` = 1 and `redir_pc` = 40. Required: next cycle `pc` = 40 and `ifid_valid` = 0; the following cycle loads word 40.
- Wrap and reset:
  - ADDR_W = 8, `pc` = 255, non-jmp word: next `pc` = 0.
  - Assert `rst_n` = 0 mid-stall: all outputs return to reset values without a clock edge.
